rca_sum_accumulator: RTL and testbench

- Downstream consumer of the ripple-carry adder stage. Takes each (WIDTH+1)-bit adder result as a valid/ready beat.
- Accumulates COUNT consecutive results into an ACC_WIDTH-bit register, then presents the total with a sticky overflow flag on a valid/ready output port.
- The output is held until it is taken. Sits between the combinational adder array and the result collection logic.

---
 rtl/rca_sum_accumulator.sv | 114 +++++++++++
 tb/tb_rca_sum_accumulator.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/rca_sum_accumulator.sv
// Burst accumulator behind the ripple-carry adder: sums COUNT results, then holds the total until taken.
// Optional build macro RCA_ACC_SATURATE_EN clamps the accumulator to all ones on overflow instead of wrapping.
module rca_sum_accumulator #(
   parameter int WIDTH     = 42,
   parameter int ACC_WIDTH = 48,
   parameter int COUNT     = 8
) (
   input  logic                         i_clk,
   input  logic                         i_rst,
   input  logic                         i_valid,
   output logic                         o_ready,
   input  logic [WIDTH:0]               i_result,
   output logic                         o_acc_valid,
   input  logic                         i_acc_ready,
   output logic [ACC_WIDTH-1:0]         o_acc,
   output logic                         o_overflow,
   output logic [$clog2(COUNT+1)-1:0]   o_beat_cnt
);

   localparam int CNT_W = $clog2(COUNT+1);
   localparam logic [CNT_W-1:0] COUNT_C = CNT_W'(COUNT);

   generate
      if (ACC_WIDTH < WIDTH + 1) begin : g_acc_width_chk
         $error("rca_sum_accumulator: ACC_WIDTH must be >= WIDTH+1");
      end
      if (COUNT < 1) begin : g_count_chk
         $error("rca_sum_accumulator: COUNT must be >= 1");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

   state_t               state, state_nxt;
   logic [ACC_WIDTH-1:0] acc, acc_nxt;
   logic [CNT_W-1:0]     cnt, cnt_nxt;
   logic                 ovf, ovf_nxt;
   logic                 accept;
   logic [ACC_WIDTH-1:0] operand;
   logic [ACC_WIDTH-1:0] wrap_sum;
   logic                 carry;

   function automatic logic [ACC_WIDTH-1:0] acc_add(input logic [ACC_WIDTH-1:0] a,
                                                    input logic [ACC_WIDTH-1:0] b);
`ifdef RCA_ACC_SATURATE_EN
      logic [ACC_WIDTH:0] s;
      s = {1'b0, a} + {1'b0, b};
      acc_add = s[ACC_WIDTH] ? '1 : s[ACC_WIDTH-1:0];
`else
      acc_add = a + b;
`endif
   endfunction

   assign o_ready     = (state != HOLD);
   assign o_acc_valid = (state == HOLD);
   assign o_acc       = acc;
   assign o_overflow  = ovf;
   assign o_beat_cnt  = cnt;

   assign accept   = i_valid && o_ready;
   assign operand  = ACC_WIDTH'(i_result);
   assign wrap_sum = acc + operand;
   // A modular sum smaller than an addend means the addition carried out of the top bit.
   assign carry    = (wrap_sum < acc);

   always_comb begin
      state_nxt = state;
      acc_nxt   = acc;
      cnt_nxt   = cnt;
      ovf_nxt   = ovf;
      case (state)
         IDLE: begin
            if (accept) begin
               acc_nxt   = operand;
               cnt_nxt   = CNT_W'(1);
               ovf_nxt   = 1'b0;
               state_nxt = (COUNT > 1) ? ACCUM : HOLD;
            end
         end
         ACCUM: begin
            if (accept) begin
               acc_nxt = acc_add(acc, operand);
               cnt_nxt = cnt + CNT_W'(1);
               ovf_nxt = ovf | carry;
               if (cnt_nxt == COUNT_C) state_nxt = HOLD;
            end
         end
         HOLD: begin
            if (i_acc_ready) begin
               acc_nxt   = '0;
               cnt_nxt   = '0;
               ovf_nxt   = 1'b0;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state <= IDLE;
         acc   <= '0;
         cnt   <= '0;
         ovf   <= 1'b0;
      end else begin
         state <= state_nxt;
         acc   <= acc_nxt;
         cnt   <= cnt_nxt;
         ovf   <= ovf_nxt;
      end
   end

endmodule

// File: tb/tb_rca_sum_accumulator.sv
// Directed bench for rca_sum_accumulator: vector table on the default build plus corner sequences
// on narrow-accumulator (COUNT=2) and single-beat (COUNT=1) instances.
module tb_rca_sum_accumulator;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // Default instance: WIDTH=42, ACC_WIDTH=48, COUNT=8
   logic        v1 = 1'b0, ar1 = 1'b0;
   logic [42:0] d1 = '0;
   logic        rdy1, av1, ovf1;
   logic [47:0] acc1;
   logic [3:0]  cnt1;

   // Narrow accumulator: WIDTH=42, ACC_WIDTH=43, COUNT=2
   logic        v2 = 1'b0, ar2 = 1'b0;
   logic [42:0] d2 = '0;
   logic        rdy2, av2, ovf2;
   logic [42:0] acc2;
   logic [1:0]  cnt2;

   // Single-beat burst: WIDTH=42, ACC_WIDTH=48, COUNT=1
   logic        v3 = 1'b0, ar3 = 1'b0;
   logic [42:0] d3 = '0;
   logic        rdy3, av3, ovf3;
   logic [47:0] acc3;
   logic [0:0]  cnt3;

   rca_sum_accumulator #(.WIDTH(42), .ACC_WIDTH(48), .COUNT(8)) dut1 (
      .i_clk(clk), .i_rst(rst), .i_valid(v1), .o_ready(rdy1), .i_result(d1),
      .o_acc_valid(av1), .i_acc_ready(ar1), .o_acc(acc1), .o_overflow(ovf1), .o_beat_cnt(cnt1));

   rca_sum_accumulator #(.WIDTH(42), .ACC_WIDTH(43), .COUNT(2)) dut2 (
      .i_clk(clk), .i_rst(rst), .i_valid(v2), .o_ready(rdy2), .i_result(d2),
      .o_acc_valid(av2), .i_acc_ready(ar2), .o_acc(acc2), .o_overflow(ovf2), .o_beat_cnt(cnt2));

   rca_sum_accumulator #(.WIDTH(42), .ACC_WIDTH(48), .COUNT(1)) dut3 (
      .i_clk(clk), .i_rst(rst), .i_valid(v3), .o_ready(rdy3), .i_result(d3),
      .o_acc_valid(av3), .i_acc_ready(ar3), .o_acc(acc3), .o_overflow(ovf3), .o_beat_cnt(cnt3));

   typedef struct {
      logic        rst;
      logic        v;
      logic [42:0] d;
      logic        ar;
      logic        ev;
      logic        er;
      logic [47:0] eacc;
      logic [3:0]  ecnt;
      logic        eovf;
   } vec_t;

   vec_t vecs[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic addv(input logic r, input logic v, input logic [42:0] d, input logic ar,
                       input logic ev, input logic er, input logic [47:0] eacc,
                       input logic [3:0] ecnt, input logic eovf);
      vec_t t;
      t.rst = r; t.v = v; t.d = d; t.ar = ar;
      t.ev = ev; t.er = er; t.eacc = eacc; t.ecnt = ecnt; t.eovf = eovf;
      vecs.push_back(t);
   endtask

   task automatic check1(input string tag, input logic ev, input logic er,
                         input logic [47:0] eacc, input logic [3:0] ecnt, input logic eovf);
      chk({tag, ".acc_valid"}, 64'(av1), 64'(ev));
      chk({tag, ".ready"},     64'(rdy1), 64'(er));
      chk({tag, ".acc"},       64'(acc1), 64'(eacc));
      chk({tag, ".beat_cnt"},  64'(cnt1), 64'(ecnt));
      chk({tag, ".overflow"},  64'(ovf1), 64'(eovf));
   endtask

   initial begin : main
      logic [47:0] run;
      logic [42:0] exp2;

      // Reset, then eight beats of 1 back to back.
      addv(1, 0, 43'h0, 0,   0, 1, 48'h0, 4'd0, 0);
      for (int k = 1; k <= 8; k++)
         addv(0, 1, 43'h1, 0,   (k == 8), (k != 8), 48'(k), 4'(k), 0);
      // Hold for five cycles with a competing beat on the input; nothing is captured.
      for (int k = 0; k < 5; k++)
         addv(0, 1, 43'h5, 0,   1, 0, 48'h8, 4'd8, 0);
      // Release; the beat presented in the same cycle is not accepted.
      addv(0, 1, 43'h5, 1,   0, 1, 48'h0, 4'd0, 0);
      // i_acc_ready in IDLE does nothing.
      addv(0, 0, 43'h0, 1,   0, 1, 48'h0, 4'd0, 0);
      // Values 1..8 with idle cycles in between (junk data, one with i_acc_ready high).
      run = 48'h0;
      for (int k = 1; k <= 8; k++) begin
         run = run + 48'(k);
         addv(0, 1, 43'(k), 0,   (k == 8), (k != 8), run, 4'(k), 0);
         if (k < 8)
            addv(0, 0, 43'h63, (k == 3),   0, 1, run, 4'(k), 0);
      end
      addv(0, 0, 43'h0, 0,   1, 0, 48'h24, 4'd8, 0);
      addv(0, 0, 43'h0, 1,   0, 1, 48'h0, 4'd0, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         rst = vecs[i].rst; v1 = vecs[i].v; d1 = vecs[i].d; ar1 = vecs[i].ar;
         tick();
         check1($sformatf("vec%0d", i), vecs[i].ev, vecs[i].er, vecs[i].eacc,
                vecs[i].ecnt, vecs[i].eovf);
      end
      rst = 1'b0; v1 = 1'b0; ar1 = 1'b0;

      // Reset in the middle of a burst discards the partial sum.
      v1 = 1'b1; d1 = 43'h7;
      for (int k = 0; k < 4; k++) tick();
      check1("partial", 0, 1, 48'h1C, 4'd4, 0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      v1 = 1'b0;
      check1("midrst", 0, 1, 48'h0, 4'd0, 0);
      v1 = 1'b1; d1 = 43'h2;
      for (int k = 0; k < 8; k++) tick();
      v1 = 1'b0;
      check1("fresh", 1, 0, 48'h10, 4'd8, 0);

      // Narrow accumulator overflow: wrap or saturate depending on the build.
`ifdef RCA_ACC_SATURATE_EN
      exp2 = 43'h7FF_FFFF_FFFF;
`else
      exp2 = 43'h7FF_FFFF_FFFE;
`endif
      v2 = 1'b1; d2 = 43'h7FF_FFFF_FFFF;
      tick();
      chk("ovf.beat1.acc", 64'(acc2), 64'h7FF_FFFF_FFFF);
      chk("ovf.beat1.overflow", 64'(ovf2), 64'd0);
      tick();
      v2 = 1'b0;
      chk("ovf.acc_valid", 64'(av2), 64'd1);
      chk("ovf.ready", 64'(rdy2), 64'd0);
      chk("ovf.acc", 64'(acc2), 64'(exp2));
      chk("ovf.overflow", 64'(ovf2), 64'd1);
      chk("ovf.beat_cnt", 64'(cnt2), 64'd2);
      tick();
      chk("ovf.sticky", 64'(ovf2), 64'd1);
      ar2 = 1'b1;
      tick();
      ar2 = 1'b0;
      chk("ovf.rel.acc_valid", 64'(av2), 64'd0);
      chk("ovf.rel.overflow", 64'(ovf2), 64'd0);
      chk("ovf.rel.acc", 64'(acc2), 64'd0);
      chk("ovf.rel.ready", 64'(rdy2), 64'd1);

      // COUNT=1: a single beat goes straight to HOLD.
      chk("one.idle.ready", 64'(rdy3), 64'd1);
      v3 = 1'b1; d3 = 43'h400_0000_0000;
      tick();
      v3 = 1'b0;
      chk("one.acc_valid", 64'(av3), 64'd1);
      chk("one.ready", 64'(rdy3), 64'd0);
      chk("one.acc", 64'(acc3), 64'h0400_0000_0000);
      chk("one.beat_cnt", 64'(cnt3), 64'd1);
      chk("one.overflow", 64'(ovf3), 64'd0);
      ar3 = 1'b1;
      tick();
      ar3 = 1'b0;
      chk("one.rel.acc_valid", 64'(av3), 64'd0);
      chk("one.rel.beat_cnt", 64'(cnt3), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
